// File: rtl/rv32i_lsu.sv
// MEM-stage load/store unit: drives a word-addressed memory port and returns extended load data.
// Optional macro RV32I_LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module rv32i_lsu #(
    parameter int TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] rdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_t      r_state, w_state;
    logic [1:0]  r_off, w_off;
    logic [2:0]  r_f3, w_f3;
    logic        r_write, w_write;
    logic [31:0] r_cnt, w_cnt;
    logic [31:0] r_rdata, w_rdata;
    logic        r_err, w_err;
    logic        r_mrd, w_mrd;
    logic        r_mwr, w_mwr;
    logic [31:0] r_maddr, w_maddr;
    logic [3:0]  r_be, w_be;
    logic [31:0] r_mwd, w_mwd;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wd;
    logic        w_mis;

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return d;
        endcase
    endfunction

    // Store lane placement; anything that is not sb/sh is treated as a full word.
    always_comb begin
        w_st_be = 4'b1111;
        w_st_wd = wdata;
        case (funct3)
            3'b000: begin
                w_st_be = 4'b0001 << addr[1:0];
                w_st_wd = wdata << {addr[1:0], 3'b000};
            end
            3'b001: begin
                w_st_be = addr[1] ? 4'b1100 : 4'b0011;
                w_st_wd = addr[1] ? {wdata[15:0], 16'b0} : wdata;
            end
            default: ;
        endcase
    end

`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    always_comb begin
        w_mis = 1'b0;
        if (req_write) begin
            if (funct3 == 3'b001)      w_mis = addr[0];
            else if (funct3 != 3'b000) w_mis = |addr[1:0];
        end else begin
            if (funct3 == 3'b001 || funct3 == 3'b101) w_mis = addr[0];
            else if (funct3 == 3'b010)                w_mis = |addr[1:0];
        end
    end
`else
    assign w_mis = 1'b0;
`endif

    always_comb begin
        w_state = r_state;
        w_off   = r_off;
        w_f3    = r_f3;
        w_write = r_write;
        w_cnt   = r_cnt;
        w_rdata = r_rdata;
        w_err   = r_err;
        w_mrd   = r_mrd;
        w_mwr   = r_mwr;
        w_maddr = r_maddr;
        w_be    = r_be;
        w_mwd   = r_mwd;
        case (r_state)
            IDLE: begin
                if (req_valid && (req_read || req_write)) begin
                    w_off   = addr[1:0];
                    w_f3    = funct3;
                    w_write = req_write;
                    w_cnt   = '0;
                    w_rdata = '0;
                    w_maddr = {addr[31:2], 2'b00};
                    w_be    = req_write ? w_st_be : 4'b0000;
                    w_mwd   = req_write ? w_st_wd : 32'b0;
                    if (w_mis) begin
                        w_err   = 1'b1;
                        w_state = RESP;
                    end else begin
                        w_err   = 1'b0;
                        w_mrd   = ~req_write;
                        w_mwr   = req_write;
                        w_state = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // A response arriving on the timeout cycle still completes normally.
                if (mem_resp) begin
                    w_mrd   = 1'b0;
                    w_mwr   = 1'b0;
                    w_rdata = r_write ? 32'b0 : load_ext(r_f3, r_off, mem_rdata);
                    w_state = RESP;
                end else if (TIMEOUT > 0 && r_cnt == TO_LAST) begin
                    w_mrd   = 1'b0;
                    w_mwr   = 1'b0;
                    w_rdata = '0;
                    w_err   = 1'b1;
                    w_state = RESP;
                end else begin
                    w_cnt = r_cnt + 32'd1;
                end
            end
            RESP:    w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_off   <= '0;
            r_f3    <= '0;
            r_write <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_mrd   <= 1'b0;
            r_mwr   <= 1'b0;
            r_maddr <= '0;
            r_be    <= '0;
            r_mwd   <= '0;
        end else begin
            r_state <= w_state;
            r_off   <= w_off;
            r_f3    <= w_f3;
            r_write <= w_write;
            r_cnt   <= w_cnt;
            r_rdata <= w_rdata;
            r_err   <= w_err;
            r_mrd   <= w_mrd;
            r_mwr   <= w_mwr;
            r_maddr <= w_maddr;
            r_be    <= w_be;
            r_mwd   <= w_mwd;
        end
    end

    assign req_ready       = (r_state == IDLE);
    assign resp_valid      = (r_state == RESP);
    assign resp_err        = (r_state == RESP) && r_err;
    assign rdata           = r_rdata;
    assign mem_address     = r_maddr;
    assign mem_read        = r_mrd;
    assign mem_write       = r_mwr;
    assign mem_byte_enable = r_be;
    assign mem_wdata       = r_mwd;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Bench for rv32i_lsu: directed cases plus randomized transactions checked against a byte-lane model.
module tb_rv32i_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] rdata, mem_address, mem_wdata;
    logic [3:0]  mem_byte_enable;

    int checks = 0;
    int errors = 0;

    rv32i_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read), .req_write(req_write),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .rdata(rdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic trap_expected(input logic wr, input logic [2:0] f3, input logic [31:0] a);
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
        if (wr) return (f3 == 3'd0) ? 1'b0 : (f3 == 3'd1) ? a[0] : (a[1:0] != 2'b00);
        if (f3 == 3'd1 || f3 == 3'd5) return a[0];
        if (f3 == 3'd2) return a[1:0] != 2'b00;
        return 1'b0;
`else
        return 1'b0 & wr & f3[0] & a[0];
`endif
    endfunction

    // dly = strobe cycles before mem_resp (0 = same cycle as first strobe); dly >= TO never responds.
    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] mr, input int dly);
        logic [3:0]  ebe;
        logic [31:0] ewd, erd, lane, half;
        logic        mis, tmo;
        lane = mr >> (8 * a[1:0]);
        half = mr >> (16 * a[1]);
        case (f3)
            3'd0:    erd = {{24{lane[7]}}, lane[7:0]};
            3'd4:    erd = {24'b0, lane[7:0]};
            3'd1:    erd = {{16{half[15]}}, half[15:0]};
            3'd5:    erd = {16'b0, half[15:0]};
            default: erd = mr;
        endcase
        if (!wr) begin
            ebe = 4'b0000; ewd = 32'b0;
        end else if (f3 == 3'd0) begin
            ebe = 4'b0001 << a[1:0]; ewd = wd << (8 * a[1:0]);
        end else if (f3 == 3'd1) begin
            ebe = 4'b0011 << (2 * a[1]); ewd = wd << (16 * a[1]);
        end else begin
            ebe = 4'b1111; ewd = wd;
        end
        mis = trap_expected(wr, f3, a);
        chk("idle_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_read = rd; req_write = wr; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; addr = $urandom; wdata = $urandom;
        if (mis) begin
            chk("trap_valid", {31'b0, resp_valid}, 32'd1);
            chk("trap_err", {31'b0, resp_err}, 32'd1);
            chk("trap_rdata", rdata, 32'd0);
            chk("trap_strobe", {30'b0, mem_read, mem_write}, 32'd0);
        end else begin
            for (int k = 0; k < TO; k++) begin
                chk("strobe", {30'b0, mem_read, mem_write}, {30'b0, ~wr, wr});
                chk("maddr", mem_address, {a[31:2], 2'b00});
                chk("be", {28'b0, mem_byte_enable}, {28'b0, ebe});
                if (wr) chk("mwdata", mem_wdata, ewd);
                chk("busy_valid", {30'b0, resp_valid, req_ready}, 32'd0);
                if (k == dly) begin mem_resp = 1'b1; mem_rdata = mr; end
                @(posedge clk); #1;
                mem_resp = 1'b0; mem_rdata = $urandom;
                if (k == dly) break;
            end
            tmo = (dly >= TO);
            chk("resp_valid", {31'b0, resp_valid}, 32'd1);
            chk("resp_err", {31'b0, resp_err}, {31'b0, tmo});
            chk("rdata", rdata, (tmo || wr) ? 32'd0 : erd);
            chk("resp_strobe", {30'b0, mem_read, mem_write}, 32'd0);
        end
        @(posedge clk); #1;
        chk("resp_pulse", {31'b0, resp_valid}, 32'd0);
        chk("back_idle", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3r;
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_outs", {29'b0, resp_valid, mem_read, mem_write}, 32'd0);
        chk("rst_be_addr", mem_address | {28'b0, mem_byte_enable} | mem_wdata | rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Reset while a read is in flight drops it silently.
        req_valid = 1'b1; req_read = 1'b1; funct3 = 3'd2; addr = 32'h4000;
        @(posedge clk); #1;
        req_valid = 1'b0; req_read = 1'b0;
        chk("pre_rst_mrd", {31'b0, mem_read}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_mrd", {31'b0, mem_read}, 32'd0);
        chk("async_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; mem_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_resp = 1'b0;
            chk("no_resp_after_rst", {31'b0, resp_valid}, 32'd0);
            chk("idle_after_rst", {31'b0, req_ready}, 32'd1);
        end

        // Request with neither read nor write is ignored.
        req_valid = 1'b1; funct3 = 3'd2; addr = 32'h5000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("nop_ready", {31'b0, req_ready}, 32'd1);
        chk("nop_strobe", {30'b0, mem_read, mem_write}, 32'd0);

        txn(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 2);
        chk("sb_be_const", {28'b0, mem_byte_enable}, 32'h8);
        txn(1'b1, 1'b0, 3'd0, 32'h0000_2002, 32'h0, 32'h0080_FF00, 0);
        chk("lb_const", rdata, 32'hFFFF_FF80);
        txn(1'b1, 1'b0, 3'd4, 32'h0000_2002, 32'h0, 32'h0080_FF00, 1);
        chk("lbu_const", rdata, 32'h0000_0080);
        txn(1'b1, 1'b0, 3'd5, 32'h0000_2002, 32'h0, 32'h0080_FF00, 0);
        chk("lhu_const", rdata, 32'h0000_0080);
        txn(1'b1, 1'b0, 3'd1, 32'h0000_2000, 32'h0, 32'h1234_8001, 0);
        chk("lh_const", rdata, 32'hFFFF_8001);
        txn(1'b1, 1'b0, 3'd2, 32'h0000_6000, 32'h0, 32'hDEAD_BEEF, 99);
        txn(1'b1, 1'b0, 3'd2, 32'h0000_6004, 32'h0, 32'hCAFE_F00D, 3);
        txn(1'b1, 1'b1, 3'd2, 32'h0000_3002, 32'h1122_3344, 32'h0, 0);
        txn(1'b0, 1'b1, 3'd1, 32'h0000_7002, 32'h0000_BEEF, 32'h0, 1);

        for (int i = 0; i < 60; i++) begin
            logic r, w;
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (!r && !w) r = 1'b1;
            f3r = 3'($urandom_range(0, 7));
            txn(r, w, f3r, $urandom, $urandom, $urandom, int'($urandom_range(0, 5)));
            if ($urandom_range(0, 3) == 0) begin
                mem_resp = 1'b1;
                @(posedge clk); #1;
                mem_resp = 1'b0;
                chk("stray_resp", {30'b0, resp_valid, req_ready}, 32'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_lsu.md
Name: rv32i_lsu

Overview:
- Load/store unit for the MEM stage. Consumes the mem_read / mem_write / funct3 fields of the rv32i control word plus the ALU-computed address.
- Drives the word-addressed data-memory port with mem_read / mem_write / mem_byte_enable / mem_resp handshake.
- Returns lane-aligned, sign- or zero-extended load data to writeback.
- Memory-facing counterpart of the decoder that generates the control word.

Parameters:
- TIMEOUT, 0, max cycles spent in ACCESS before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM-stage request valid.
- req_ready  out  1  LSU can accept a request this cycle.
- req_read  in  1  control word mem_read.
- req_write  in  1  control word mem_write.
- funct3  in  3  load_funct3_t / store_funct3_t encoding.
- addr  in  32  byte address.
- wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_err  out  1  qualifies resp_valid: timeout or misalign.
- rdata  out  32  extended load data, valid with resp_valid; stores return 0.
- mem_address  out  32  {addr[31:2], 2'b00}.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_byte_enable  out  4  write lane mask.
- mem_wdata  out  32  lane-shifted store data.
- mem_rdata  in  32  memory read data.
- mem_resp  in  1  memory completion, one cycle.

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0 except req_ready=1. Timeout counter=0. An in-flight access is dropped with no response.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1.
  - req_valid & (req_read|req_write): capture addr, wdata, funct3, op; go to ACCESS.
  - Both req_read and req_write set: write wins.
  - req_valid with neither set: ignored; stay in IDLE.
- ACCESS: mem_read or mem_write held high with stable mem_address, mem_byte_enable and mem_wdata.
  - Registered outputs; strobes assert the cycle after accept.
  - On mem_resp: latch extended rdata; drop strobes next cycle; go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 during ACCESS and RESP.
- Minimum latency: accept at cycle N, strobe at N+1, mem_resp at N+1, resp_valid at N+2.
- mem_resp seen in IDLE or RESP is ignored.
- Store lanes, with off=addr[1:0]:
  - sb: be=4'b0001<<off, mem_wdata=wdata<<(8*off).
  - sh: be=4'b0011<<{addr[1],0}, mem_wdata=wdata<<(16*addr[1]).
  - sw: be=4'b1111, mem_wdata=wdata.
  - funct3 011/1xx on a store is treated as sw.
- Loads:
  - mem_byte_enable=0.
  - lb/lbu: byte at lane off, sign-/zero-extended.
  - lh/lhu: half at addr[1], sign-/zero-extended.
  - lw, and any undefined funct3, returns the full word.
- Without the optional feature, misaligned low address bits are ignored as above.
- Timeout (TIMEOUT>0): counter increments each ACCESS cycle.
  - When it reaches TIMEOUT without mem_resp: drop strobes, go to RESP with resp_err=1, rdata=0.
  - mem_resp arriving in that same cycle wins: normal completion.
  - Counter clears on entry to ACCESS.

Optional Feature:
- Macro: RV32I_LSU_MISALIGN_TRAP_EN.
- Defined: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0, skips ACCESS. No strobe is issued; go directly to RESP with resp_err=1, rdata=0. resp_valid fires one cycle after accept.
- Undefined: no check; low bits are masked as in Behaviour and resp_err is driven only by timeout.

Test Plan:
- Reset mid-ACCESS (mem_read=1), rst low async -> mem_read=0, req_ready=1 immediately; no resp_valid after reset release.
- sb addr=0x1003 wdata=0x000000A5, mem_resp 2 cycles after strobe -> mem_address=0x1000, be=4'b1000, mem_wdata=0xA5000000; resp_valid one cycle after mem_resp, resp_err=0.
- lb addr=0x2002, mem_rdata=0x0080FF00 -> rdata=0xFFFFFF80. Same with lbu -> 0x00000080. lhu addr=0x2002 -> 0x00000080.
- lh addr=0x2000, mem_rdata=0x1234_8001 -> rdata=0xFFFF8001.
- TIMEOUT=4, mem_resp never asserted -> strobe high 4 cycles, then resp_valid=1, resp_err=1, rdata=0. Separately, mem_resp on the 4th cycle -> resp_err=0.
- MISALIGN_TRAP_EN defined: sw addr=0x3002 -> no mem_write; resp_valid with resp_err=1 one cycle after accept. Undefined: mem_write with mem_address=0x3000, be=4'b1111.
